bitmap_scan_controller: RTL and testbench

Sequences scan-out of the 640×480, 1 bit-per-pixel display bitmap. It generates VGA 640×480@60 timing and fetches 16-bit bitmap words from a single-port synchronous RAM into a pixel shift register. It arbitrates that RAM between its own display reads, which have fixed priority, and a host write port with a valid/ready handshake. It sits between the bitmap RAM and the VGA output pins, replacing per-pixel random lookup into a flat bitmap.

---
 rtl/bitmap_pkg.sv | 26 ++
 rtl/vga_timing_gen.sv | 81 ++++++++
 rtl/bitmap_scan_controller.sv | 132 +++++++++++++
 tb/tb_bitmap_scan_controller.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitmap_pkg.sv
// Shared constants for the 1bpp bitmap scan-out path.
// Default VGA 640x480@60 timing and bitmap geometry.
package bitmap_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_WORD_W   = 16;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP
                         + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP
                         + DEF_V_SYNC + DEF_V_BP;

  localparam int WORDS_PER_LINE = 40;
  localparam int WORD_COUNT     = 19200;
  localparam int ADDR_W         = 15;

  localparam int CNT_W = 10;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v counters with registered sync, de and
// pixel coordinates; all outputs describe the previous count.
module vga_timing_gen
  import bitmap_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [9:0]       x,
  output logic [8:0]       y,
  output logic             frame_start
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_RST  = CNT_W'(HT - 4);
  localparam logic [CNT_W-1:0] HS0 = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS1 = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS0 = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS1 = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic active;
  logic in_hs;
  logic in_vs;

  assign active = (h < H_ACT) && (v < V_ACT);
  assign in_hs  = (h >= HS0) && (h < HS1);
  assign in_vs  = (v >= VS0) && (v < VS1);

  // Preload so the first line-0 word fetch lands in the first frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= H_RST;
      v <= V_LAST;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ~in_hs;
      vsync       <= ~in_vs;
      de          <= active;
      frame_start <= (h == '0) && (v == '0);
      if (active) begin
        x <= h;
        y <= v[8:0];
      end
    end
  end

endmodule

// File: rtl/bitmap_scan_controller.sv
// 1bpp bitmap scan-out: fixed-slot display reads from a
// single-port RAM, host writes fill the remaining cycles.
module bitmap_scan_controller
  import bitmap_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int WORD_W   = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WORD_W-1:0] host_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [9:0]        x,
  output logic [8:0]        y,
  output logic              pixel_on,
  output logic              frame_start
);

  localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int WPL = H_ACTIVE / WORD_W;

  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SMAX = CNT_W'(H_ACTIVE - 18);
  localparam logic [CNT_W-1:0] H_EDGE = CNT_W'(HT - 2);
  localparam logic [CNT_W-1:0] V_PRE  = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VT - 1);

  localparam logic [ADDR_W-1:0] WPL_A = ADDR_W'(WPL);
  localparam logic [ADDR_W-1:0] WC_A  = ADDR_W'(WORD_COUNT);

  logic [CNT_W-1:0]  h;
  logic [CNT_W-1:0]  v;
  logic              line_slot;
  logic              edge_slot;
  logic              slot;
  logic [CNT_W-1:0]  rd_row;
  logic [5:0]        rd_word;
  logic [ADDR_W-1:0] rd_addr;
  logic              active;
  logic              first;
  logic              bit_now;
  logic              rd_q;
  logic [WORD_W-1:0] hold;
  logic [WORD_W-1:0] shift;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .h           (h),
    .v           (v),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .frame_start (frame_start)
  );

  // Word k is read at h=16k-2; word 0 borrows h=HT-2 of the prior line.
  assign line_slot = (v < V_ACT) && (h[3:0] == 4'd14)
                  && (h <= H_SMAX);
  assign edge_slot = (h == H_EDGE)
                  && ((v == V_LAST) || (v < V_PRE));
  assign slot      = line_slot | edge_slot;

  always_comb begin
    rd_row  = v;
    rd_word = 6'((h + 10'd2) >> 4);
    if (edge_slot) begin
      rd_row  = (v == V_LAST) ? '0 : v + 1'b1;
      rd_word = '0;
    end
  end

  assign rd_addr = ADDR_W'(rd_row) * WPL_A + ADDR_W'(rd_word);

  assign mem_rd     = rst_n & slot;
  assign host_ready = rst_n & ~slot;
  assign mem_wr     = host_valid & host_ready & (host_addr < WC_A);
  assign mem_addr   = slot ? rd_addr : host_addr;
  assign mem_wdata  = host_data;

  assign active  = (h < H_ACT) && (v < V_ACT);
  assign first   = (h[3:0] == 4'd0);
  assign bit_now = first ? hold[WORD_W-1] : shift[WORD_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= 1'b0;
      hold     <= '0;
      shift    <= '0;
      pixel_on <= 1'b0;
    end else begin
      rd_q <= mem_rd;
      if (rd_q) hold <= mem_rdata;
      if (active) begin
        shift <= first ? {hold[WORD_W-2:0], 1'b0}
                       : {shift[WORD_W-2:0], 1'b0};
      end
      pixel_on <= active & bit_now;
    end
  end

endmodule

// File: tb/tb_bitmap_scan_controller.sv
// Randomized host traffic against a frame-position model of
// the scan controller, run with a shortened vertical frame.
module tb_bitmap_scan_controller;

  localparam int VA = 6;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VT = VA + VF + VS + VB;
  localparam int HT = 800;
  localparam int FRAME = HT * VT;
  localparam int NW = 19200;
  localparam int START = (VT - 1) * HT + 796;
  localparam int NCYC = 42000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [14:0] host_addr = '0;
  logic [15:0] host_data = '0;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        pixel_on;
  logic        frame_start;

  always #5 clk = ~clk;

  bitmap_scan_controller #(
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .pixel_on    (pixel_on),
    .frame_start (frame_start)
  );

  logic [15:0] ram    [0:NW-1];
  logic [15:0] shadow [0:NW-1];
  logic [15:0] lbuf   [0:39];

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= ram[mem_addr];
    if (mem_wr) ram[mem_addr] <= mem_wdata;
  end

  int total = 0;
  int bad = 0;
  int c, n, edges, xs, ys;
  bit hs_done = 0;
  bit seen_rd = 0;
  bit did_mid = 0;
  bit win = 0;
  int rcnt = 0;
  int fs_last = -1;
  int fs_cnt = 0;
  int hrun = 0;
  int hs_oor = 0;
  int wr_oor = 0;
  bit r0 [0:39];
  bit r1 [0:39];
  bit a5 [0:2];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s n=%0d c=%0d got=%0h want=%0h",
               nm, n, c, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_de"}, int'(de), 0);
    chk({tag, "_pix"}, int'(pixel_on), 0);
    chk({tag, "_x"}, int'(x), 0);
    chk({tag, "_y"}, int'(y), 0);
    chk({tag, "_fs"}, int'(frame_start), 0);
    chk({tag, "_rd"}, int'(mem_rd), 0);
    chk({tag, "_wr"}, int'(mem_wr), 0);
    chk({tag, "_ready"}, int'(host_ready), 0);
  endtask

  // Registered outputs show position c-1; RAM strobes show c.
  task automatic step();
    int p, h, v, nx, hn, vn, wa;
    bit ede, epix, erd, ewr;
    p = (c + FRAME - 1) % FRAME;
    h = p % HT;
    v = p / HT;
    ede = (h < 640) && (v < VA);
    if (ede) begin
      xs = h;
      ys = v;
    end
    epix = ede ? lbuf[h / 16][15 - (h % 16)] : 1'b0;
    chk("de", int'(de), int'(ede));
    chk("hsync", int'(hsync), int'(!(h >= 656 && h < 752)));
    chk("vsync", int'(vsync),
        int'(!(v >= VA + VF && v < VA + VF + VS)));
    chk("x", int'(x), xs);
    chk("y", int'(y), ys);
    chk("pixel_on", int'(pixel_on), int'(epix));
    chk("frame_start", int'(frame_start), int'(p == 0));

    nx = (c + 2) % FRAME;
    hn = nx % HT;
    vn = nx / HT;
    erd = (hn < 640) && (vn < VA) && (hn % 16 == 0);
    ewr = host_valid && !erd && (int'(host_addr) < NW);
    chk("mem_rd", int'(mem_rd), int'(erd));
    chk("host_ready", int'(host_ready), int'(!erd));
    chk("mem_wr", int'(mem_wr), int'(ewr));
    chk("rd_and_wr", int'(mem_rd & mem_wr), 0);
    if (erd) begin
      wa = vn * 40 + hn / 16;
      chk("rd_addr", int'(mem_addr), wa);
      lbuf[hn / 16] = shadow[wa];
    end
    if (ewr) begin
      chk("wr_addr", int'(mem_addr), int'(host_addr));
      chk("wr_data", int'(mem_wdata), int'(host_data));
      shadow[host_addr] = host_data;
    end
    hs_done = host_valid && !erd;
  endtask

  task automatic drive_host();
    int a;
    if (n < 3200) begin
      host_valid = 1'b0;
    end else if (n < 3400) begin
      host_valid = 1'b1;
      host_addr  = 15'd5;
      host_data  = 16'hA5A5;
    end else if (n < 3500) begin
      host_valid = 1'b1;
      host_addr  = 15'd19200;
      host_data  = 16'h5A5A;
    end else if (!(host_valid && !hs_done)) begin
      host_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        a = 19200 + $urandom_range(0, 13567);
      else
        a = $urandom_range(0, 299);
      if (a == 5) a = 6;
      host_addr = 15'(a);
      host_data = 16'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end
    for (int i = 0; i < 40; i++) lbuf[i] = '0;
    ram[0] = 16'h8001;
    shadow[0] = 16'h8001;
    ram[41] = 16'hFFFF;
    shadow[41] = 16'hFFFF;

    host_valid = 1'b1;
    host_addr  = 15'd7;
    host_data  = 16'h1234;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    host_valid = 1'b0;
    rst_n = 1'b1;
    c = START;
    edges = 0;
    xs = 0;
    ys = 0;

    for (n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      c = (c + 1) % FRAME;
      edges++;
      drive_host();
      @(negedge clk);
      if (c == 0) begin
        if (win) chk("reads_per_frame", rcnt, VA * 40);
        win = 1;
        rcnt = 0;
      end
      if (win && mem_rd) rcnt++;
      step();
      if (!seen_rd && mem_rd) begin
        seen_rd = 1;
        chk("first_rd_edges", edges, 2);
        chk("first_rd_addr", int'(mem_addr), 0);
      end
      if (n < 3200 && de && x < 40 && y == 0) r0[x] = pixel_on;
      if (n < 3200 && de && x < 40 && y == 1) r1[x] = pixel_on;
      if (n > 10000 && n < 20000 && de && y == 0
          && x >= 80 && x < 83)
        a5[x - 80] = pixel_on;
      if (n >= 3400 && n < 3500) begin
        if (mem_wr) wr_oor++;
        if (host_valid && host_ready) hs_oor++;
      end
      if (frame_start) begin
        if (fs_last >= 0) chk("frame_period", n - fs_last, FRAME);
        fs_last = n;
        fs_cnt++;
      end
      if (!hsync) hrun++;
      else if (hrun > 0) begin
        chk("hsync_len", hrun, 96);
        hrun = 0;
      end
      if (!did_mid && n >= 25000 && de && x == 300 && y == 2) begin
        host_valid = 1'b1;
        host_addr  = 15'd9;
        host_data  = 16'hBEEF;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        chk_reset_outputs("midhold");
        host_valid = 1'b0;
        rst_n = 1'b1;
        did_mid = 1;
        c = START;
        edges = 0;
        xs = 0;
        ys = 0;
        hs_done = 0;
        win = 0;
        fs_last = -1;
        hrun = 0;
      end
    end

    chk("pix_0_0", int'(r0[0]), 1);
    chk("pix_1_0", int'(r0[1]), 0);
    chk("pix_15_0", int'(r0[15]), 1);
    chk("pix_16_0", int'(r0[16]), 0);
    chk("pix_15_1", int'(r1[15]), 0);
    chk("pix_16_1", int'(r1[16]), 1);
    chk("pix_31_1", int'(r1[31]), 1);
    chk("pix_32_1", int'(r1[32]), 0);
    chk("a5_80", int'(a5[0]), 1);
    chk("a5_81", int'(a5[1]), 0);
    chk("a5_82", int'(a5[2]), 1);
    chk("ram_word5", int'(ram[5]), 16'hA5A5);
    chk("ram_word9_kept", int'(ram[9] == 16'hBEEF), 0);
    chk("oor_handshake", int'(hs_oor > 0), 1);
    chk("oor_no_write", wr_oor, 0);
    chk("frame_pulses", int'(fs_cnt >= 3), 1);
    chk("mid_reset_hit", int'(did_mid), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
